// File: rtl/rptr_level_ctrl.sv
// Read-side pointer and flag controller for an asynchronous FIFO.
// It decodes the synchronized Gray write pointer and keeps the binary and Gray read pointers.
// It also tracks the readable fill level, the empty and almost-empty flags, and a sticky underflow flag.
// A flush moves the read pointer onto the synchronized write pointer, which drains the FIFO.
module rptr_level_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                rflush,
    input  logic                runderflow_clr,
    input  logic [ADDRSIZE:0]   arempty_thresh,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] levelnext;
    logic              rd_ok;
    logic              underflow_set;

    // Decode the synchronized Gray write pointer.
    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Compute the next read pointer, Gray code, and level.
    // A flush takes priority over a read request and ignores it.
    // A read request is honoured only while the FIFO is not empty.
    always_comb begin
        rd_ok         = rinc & ~rempty;
        underflow_set = rinc & rempty & ~rflush;
        if (rflush) begin
            rbinnext = wbin;
        end else begin
            rbinnext = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
        end
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        levelnext = wbin - rbinnext;
    end

    // Register the pointers and the flags derived from the next-state values.
    // The sticky underflow flag is cleared on request, but a new underflow in the same cycle wins.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            arempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            arempty <= (levelnext <= arempty_thresh);
            rlevel  <= levelnext;
            if (underflow_set) begin
                runderflow <= 1'b1;
            end else if (runderflow_clr) begin
                runderflow <= 1'b0;
            end
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule
